// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  // Discard counter width: redirects can stack up wrong-path responses.
  localparam int unsigned DROP_W = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        likely;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Prefetch FIFO between instruction memory responses and the IF/ID register.
module if_fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: issues sequential fetches, buffers in-order responses and feeds IF/ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_likely,
  input  logic        stall,
  output logic [31:0] IF_PC_plus_4,
  output logic [31:0] IF_Instruction,
  output logic        IF_Branch_likely
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  // Request channel: valid/ready; a raised request keeps its address until
  // accepted, except that a redirect withdraws it for one cycle.
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       fill_pc_q, fill_pc_d;
  logic [31:0]       deliver_pc_q, deliver_pc_d;
  logic [CW-1:0]     live_q, live_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              likely_pending_q, likely_pending_d;

  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  fetch_entry_t      fifo_head, push_entry;
  logic              push, pop, req_fire, resp_drop;
  logic [CW:0]       credit_used;

  assign credit_used    = {1'b0, live_q} + {1'b0, fifo_count};
  assign imem_req_valid = !redirect_valid && !fifo_full && (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_q != '0);
  assign push      = imem_resp_valid && (drop_q == '0) && !redirect_valid;
  assign pop       = !fifo_empty && !stall && !redirect_valid;

  assign push_entry = '{pc: fill_pc_q, instr: imem_resp_data, likely: likely_pending_q};

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    fill_pc_d        = fill_pc_q;
    deliver_pc_d     = deliver_pc_q;
    live_d           = live_q;
    drop_d           = drop_q;
    likely_pending_d = likely_pending_q;
    if (redirect_valid) begin
      // Everything in flight becomes wrong-path; a response arriving now
      // is retired against that total.
      fetch_pc_d       = redirect_pc;
      fill_pc_d        = redirect_pc;
      deliver_pc_d     = redirect_pc;
      likely_pending_d = redirect_likely;
      live_d           = '0;
      drop_d           = drop_q + DROP_W'(live_q) - DROP_W'(imem_resp_valid);
    end else begin
      if (req_fire)  fetch_pc_d   = fetch_pc_q + 32'd4;
      if (pop)       deliver_pc_d = deliver_pc_q + 32'd4;
      if (resp_drop) drop_d       = drop_q - 1'b1;
      if (push) begin
        fill_pc_d        = fill_pc_q + 32'd4;
        likely_pending_d = 1'b0;
      end
      live_d = live_q + CW'(req_fire) - CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q       <= RESET_PC;
      fill_pc_q        <= RESET_PC;
      deliver_pc_q     <= RESET_PC;
      live_q           <= '0;
      drop_q           <= '0;
      likely_pending_q <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      fill_pc_q        <= fill_pc_d;
      deliver_pc_q     <= deliver_pc_d;
      live_q           <= live_d;
      drop_q           <= drop_d;
      likely_pending_q <= likely_pending_d;
    end
  end

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  // Empty FIFO presents a nop bubble tagged with the next PC to deliver.
  always_comb begin
    if (fifo_empty) begin
      IF_PC_plus_4     = deliver_pc_q + 32'd4;
      IF_Instruction   = NOP_INSTR;
      IF_Branch_likely = 1'b0;
    end else begin
      IF_PC_plus_4     = fifo_head.pc + 32'd4;
      IF_Instruction   = fifo_head.instr;
      IF_Branch_likely = fifo_head.likely;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order memory model and a delivery scoreboard.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        redirect_likely = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] IF_PC_plus_4, IF_Instruction;
  logic        IF_Branch_likely;

  logic        req_valid_w, req_ready_w = 1'b0;
  logic [31:0] req_addr_w;
  logic        resp_valid_w = 1'b0;
  logic [31:0] resp_data_w = '0;
  logic [31:0] pc4_w, instr_w;
  logic        likely_w;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_likely(redirect_likely),
    .stall(stall),
    .IF_PC_plus_4(IF_PC_plus_4), .IF_Instruction(IF_Instruction), .IF_Branch_likely(IF_Branch_likely)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid_w), .imem_req_ready(req_ready_w), .imem_req_addr(req_addr_w),
    .imem_resp_valid(resp_valid_w), .imem_resp_data(resp_data_w),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_likely(redirect_likely),
    .stall(stall),
    .IF_PC_plus_4(pc4_w), .IF_Instruction(instr_w), .IF_Branch_likely(likely_w)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_cnt = 0;
  logic resp_en = 1'b0;
  logic last_req_valid = 1'b0;
  logic [64:0] exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_t_q[$];
  logic [31:0] hs_log[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: present the memory response, record an accepted request,
  // advance past the edge and retire the consumed response.
  task automatic cycle();
    if (resp_en && mem_addr_q.size() > 0 && mem_t_q[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(mem_addr_q[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
    last_req_valid = imem_req_valid;
    if (reset && imem_req_valid && imem_req_ready) begin
      mem_addr_q.push_back(imem_req_addr);
      mem_t_q.push_back(cyc + 1);
      hs_log.push_back(imem_req_addr);
      hs_cnt++;
    end
    @(posedge clk);
    cyc++;
    if (reset && imem_resp_valid) begin
      void'(mem_addr_q.pop_front());
      void'(mem_t_q.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_req_ready = 1'b0; resp_en = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_likely = 1'b0;
    req_ready_w = 1'b0; resp_valid_w = 1'b0;
    mem_addr_q.delete(); mem_t_q.delete(); exp_q.delete();
    repeat (2) cycle();
    reset = 1'b1;
    hs_cnt = 0;
    hs_log.delete();
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n, input logic first_likely);
    for (int i = 0; i < n; i++) begin
      logic [31:0] pc;
      pc = start + 32'(4 * i);
      exp_q.push_back({pc + 32'd4, mem_data(pc), (i == 0) ? first_likely : 1'b0});
    end
  endtask

  task automatic run_stream(input int n, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (hs_cnt >= n && exp_q.size() == 0) break;
      imem_req_ready = (hs_cnt < n);
      cycle();
    end
    imem_req_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d deliveries outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_hs_seq(input logic [31:0] start, input int n);
    check32("req_count", 32'(hs_log.size()), 32'(n));
    for (int i = 0; i < hs_log.size(); i++)
      check32("req_addr_seq", hs_log[i], start + 32'(4 * i));
  endtask

  // Scoreboard monitor: a non-bubble head that is neither stalled nor
  // flushed retires this cycle and must match the next expected entry.
  always @(negedge clk) begin
    if (reset) begin
      if (!stall && !redirect_valid && IF_Instruction != 32'h0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_delivery: got pc4=%h instr=%h likely=%b, expected none",
                   IF_PC_plus_4, IF_Instruction, IF_Branch_likely);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          if ({IF_PC_plus_4, IF_Instruction, IF_Branch_likely} !== e) begin
            errors++;
            $display("FAIL delivery: got pc4=%h instr=%h likely=%b, expected pc4=%h instr=%h likely=%b",
                     IF_PC_plus_4, IF_Instruction, IF_Branch_likely, e[64:33], e[32:1], e[0]);
          end
        end
      end
      if (imem_resp_valid) begin
        checks++;
        if (dut.live_q == '0 && dut.drop_q == '0) begin
          errors++;
          $display("FAIL protocol: response with live=0 drop=0, expected an outstanding request");
        end
      end
    end
  end

  initial begin
    // Reset bubble and first fill.
    reset = 1'b0;
    cycle();
    check32("reset_pc4", IF_PC_plus_4, 32'h4);
    check32("reset_instr", IF_Instruction, 32'h0);
    check32("reset_likely", 32'(IF_Branch_likely), 32'h0);
    do_reset();
    check32("post_reset_addr", imem_req_addr, 32'h0);
    check32("post_reset_pc4", IF_PC_plus_4, 32'h4);
    expect_seq(32'h0, 6, 1'b0);
    imem_req_ready = 1'b1; resp_en = 1'b1;
    cycle();
    check32("addr_after_first", imem_req_addr, 32'h4);
    cycle();
    check32("first_fill_pc4", IF_PC_plus_4, 32'h4);
    check32("first_fill_instr", IF_Instruction, 32'hA5A5_0000);
    run_stream(6, 60);
    check_hs_seq(32'h0, 6);

    // Credit limit, then full FIFO under stall.
    do_reset();
    expect_seq(32'h0, 8, 1'b0);
    stall = 1'b1; imem_req_ready = 1'b1;
    repeat (8) cycle();
    check32("credit_hs", 32'(hs_cnt), 32'd4);
    check32("credit_req_valid", 32'(imem_req_valid), 32'h0);
    resp_en = 1'b1;
    repeat (4) cycle();
    check32("full_req_valid", 32'(imem_req_valid), 32'h0);
    repeat (5) begin
      cycle();
      check32("stall_pc4", IF_PC_plus_4, 32'h4);
      check32("stall_instr", IF_Instruction, 32'hA5A5_0000);
    end
    check32("stall_hs", 32'(hs_cnt), 32'd4);
    stall = 1'b0;
    #1;
    check32("no_req_before_pop", 32'(imem_req_valid), 32'h0);
    run_stream(8, 80);
    check_hs_seq(32'h0, 8);

    // Redirect with three requests outstanding.
    do_reset();
    imem_req_ready = 1'b1;
    for (int i = 0; i < 10 && hs_cnt < 3; i++) cycle();
    check32("pre_redirect_hs", 32'(hs_cnt), 32'd3);
    hs_cnt = 0; hs_log.delete();
    expect_seq(32'h400, 4, 1'b1);
    resp_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h400; redirect_likely = 1'b1;
    cycle();
    check32("redirect_no_req", 32'(last_req_valid), 32'h0);
    redirect_valid = 1'b0; redirect_likely = 1'b0;
    run_stream(4, 60);
    check_hs_seq(32'h400, 4);

    // Redirect colliding with a response, a poppable head and stall.
    do_reset();
    resp_en = 1'b1; imem_req_ready = 1'b1;
    cycle();
    cycle();
    check32("pre_collide_head", IF_Instruction, 32'hA5A5_0000);
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h800;
    cycle();
    check32("collide_no_req", 32'(last_req_valid), 32'h0);
    check32("collide_bubble_instr", IF_Instruction, 32'h0);
    check32("collide_bubble_likely", 32'(IF_Branch_likely), 32'h0);
    check32("collide_bubble_pc4", IF_PC_plus_4, 32'h804);
    check32("collide_fetch_addr", imem_req_addr, 32'h800);
    redirect_valid = 1'b0;
    hs_cnt = 0; hs_log.delete();
    expect_seq(32'h800, 2, 1'b0);
    imem_req_ready = 1'b1;
    cycle();
    check32("stall_bubble_pc4", IF_PC_plus_4, 32'h804);
    check32("stall_bubble_instr", IF_Instruction, 32'h0);
    imem_req_ready = (hs_cnt < 2);
    cycle();
    check32("stall_fill_pc4", IF_PC_plus_4, 32'h804);
    check32("stall_fill_instr", IF_Instruction, mem_data(32'h800));
    stall = 1'b0;
    run_stream(2, 40);
    check_hs_seq(32'h800, 2);

    // Address wrap from a high reset PC.
    do_reset();
    check32("wrap_reset_pc4", pc4_w, 32'hFFFF_FFFC);
    check32("wrap_reset_addr", req_addr_w, 32'hFFFF_FFF8);
    check32("wrap_reset_valid", 32'(req_valid_w), 32'h1);
    req_ready_w = 1'b1;
    cycle();
    check32("wrap_addr1", req_addr_w, 32'hFFFF_FFFC);
    resp_valid_w = 1'b1; resp_data_w = mem_data(32'hFFFF_FFF8);
    cycle();
    check32("wrap_addr2", req_addr_w, 32'h0000_0000);
    check32("wrap_head0_pc4", pc4_w, 32'hFFFF_FFFC);
    check32("wrap_head0_instr", instr_w, mem_data(32'hFFFF_FFF8));
    req_ready_w = 1'b0; resp_data_w = mem_data(32'hFFFF_FFFC);
    cycle();
    check32("wrap_head1_pc4", pc4_w, 32'h0000_0000);
    check32("wrap_head1_instr", instr_w, mem_data(32'hFFFF_FFFC));
    resp_valid_w = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
